// File: rtl/bcd_count_4digit.sv
// Purpose : four-digit BCD up/down event counter stepped by a built-in prescaler tick.
// Latency : one cycle; digits, tick and carry all update on the step edge and show together next cycle.
// Backpres: none; the count has no consumer handshake, and en=0 freezes the prescaler and digits.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       synchronous active-high reset (beats load, beats step)
//   en        1 = prescaler runs and digits step, 0 = hold everything
//   up_dn     count direction, sampled only on a step edge (1 = up)
//   load      synchronous parallel load strobe, works whether en is high or low
//   load_val  BCD load value, [3:0]=d0 .. [15:12]=d3; nibbles above 9 load as 0
//   d0..d3    registered BCD digits, d0 least significant
//   tick      one-cycle pulse in the cycle a new count first appears
//   carry     one-cycle pulse coincident with tick on 9999<->0000 wrap
module bcd_count_4digit #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up_dn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic        tick,
    output logic        carry
);

    // Terminal prescaler value; the step happens on the edge that would leave it.
    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]     pre_q;
    logic [3:0][3:0]      dig_q;
    logic                 tick_q;
    logic                 carry_q;

    logic                 step;
    logic [3:0][3:0]      dig_step;
    logic                 wrap;
    logic [3:0][3:0]      dig_load;

    // A step needs the counter enabled, no load competing, and the prescaler at its last phase.
    assign step = en && !load && (pre_q == PRE_LAST);

    // Ripple the +1/-1 through the digits. 'wrap' starts as the incoming
    // carry/borrow into d0 and stays set only if every digit rolled over,
    // which is exactly the 9999->0000 / 0000->9999 case.
    always_comb begin
        dig_step = dig_q;
        wrap     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (wrap) begin
                if (up_dn) begin
                    if (dig_q[i] >= 4'd9) begin
                        dig_step[i] = 4'd0;
                    end else begin
                        dig_step[i] = dig_q[i] + 4'd1;
                        wrap        = 1'b0;
                    end
                end else begin
                    if (dig_q[i] == 4'd0) begin
                        dig_step[i] = 4'd9;
                    end else begin
                        dig_step[i] = dig_q[i] - 4'd1;
                        wrap        = 1'b0;
                    end
                end
            end
        end
    end

    // Sanitise the parallel load so digits can never hold 10..15.
    always_comb begin
        dig_load = '0;
        for (int i = 0; i < 4; i++) begin
            dig_load[i] = (load_val[i*4 +: 4] > 4'd9) ? 4'd0 : load_val[i*4 +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            dig_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (load) begin
            // Load also restarts the prescaler phase and swallows any step due now.
            pre_q   <= '0;
            dig_q   <= dig_load;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (step) begin
            pre_q   <= '0;
            dig_q   <= dig_step;
            tick_q  <= 1'b1;
            carry_q <= wrap;
        end else begin
            // With en low the prescaler phase is kept so re-enabling resumes mid-period.
            if (en) begin
                pre_q <= pre_q + DIV_W'(1);
            end
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end
    end

    assign d0    = dig_q[0];
    assign d1    = dig_q[1];
    assign d2    = dig_q[2];
    assign d3    = dig_q[3];
    assign tick  = tick_q;
    assign carry = carry_q;

endmodule

// File: doc/bcd_count_4digit.md
Name: bcd_count_4digit

Overview:
Four-digit BCD up/down event counter with a built-in prescaler. It feeds the seven-segment display path: its four BCD digit outputs connect directly to the multiplexed display driver's digit inputs (d0 = least significant). It replaces hard-wired zero digits with a live count that steps once per prescaled tick. It also supports parallel BCD load, count direction, enable, and wrap/borrow indication.

Parameters:
TICK_DIV, 50000000, clk cycles per count step (1 Hz at 50 MHz); legal range 1..2^DIV_W
DIV_W, 26, prescaler counter width; must satisfy 2^DIV_W >= TICK_DIV

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = prescaler runs and digits step; 0 = everything holds
up_dn  input  1  1 = count up, 0 = count down; sampled at each step
load  input  1  synchronous parallel load strobe
load_val  input  16  BCD load value; [3:0]=d0 .. [15:12]=d3
d0  output  4  BCD units digit, registered
d1  output  4  BCD tens digit, registered
d2  output  4  BCD hundreds digit, registered
d3  output  4  BCD thousands digit, registered
tick  output  1  one-cycle pulse, high in the cycle the new count first appears
carry  output  1  one-cycle pulse on wrap (9999->0000 up, 0000->9999 down), coincident with tick

Behaviour:
- Reset values: rst=1 at an edge -> d0..d3=0, tick=0, carry=0, prescaler=0. Reset has the highest priority over load, en, and any step. Reset mid-count discards the prescaler phase.
- Priority at each edge: rst > load > step > hold.
- Prescaler: counts 0..TICK_DIV-1 while en=1 and load=0; holds its value while en=0.
- Step: occurs at an edge where en=1, load=0, and prescaler==TICK_DIV-1. At that edge:
  - prescaler<=0
  - tick<=1
  - digits update by +1 or -1 per up_dn
  - latency: new digit values and tick are visible together in the following cycle
- tick and carry are 0 in every cycle without a step. They are never high for 2 consecutive cycles unless TICK_DIV=1, in which case they step every enabled cycle.
- BCD up: a digit at 9 rolls to 0 and increments the next digit. 9999 -> 0000 with carry=1.
- BCD down: a digit at 0 rolls to 9 and decrements the next digit. 0000 -> 9999 with carry=1.
- Digits never hold values 10..15.
- Load (load=1, rst=0):
  - d0..d3 <= load_val nibbles
  - any nibble >9 is loaded as 0; the other nibbles load normally
  - prescaler<=0, tick<=0, carry<=0
  - load overrides a step due on the same edge (that step is lost)
  - load is effective regardless of en
- en=0: digits, prescaler, and up_dn effect frozen; tick=carry=0. Re-enabling resumes from the held prescaler phase, so the first step arrives TICK_DIV - held_phase cycles later.
- up_dn may change at any time. Only its value at a step edge matters.
- Outputs are all registered. No combinational path from inputs to outputs.

Test Plan:
1. TICK_DIV=4: rst 2 cycles, then en=1, up_dn=1 -> d=0000 during reset. tick high every 4th cycle. Digits 0001 after first tick, 0010 after 10 ticks. carry stays 0.
2. TICK_DIV=4: load load_val=16'h9998, then en=1, up_dn=1 -> 9999 on tick 1; 0000 with carry=1 and tick=1 on the same cycle at tick 2; 0001 with carry=0 at tick 3.
3. TICK_DIV=4: load 16'h0001, up_dn=0 -> 0000 on tick 1; 9999 with carry=1 on tick 2; 9998 on tick 3. Also load 16'h1000, down -> 0999.
4. Load 16'hA3F7 -> d3=0, d2=3, d1=0, d0=7. Load asserted on a step edge -> tick=0, digits = load value, prescaler restarts (next tick 4 cycles later).
5. TICK_DIV=4: run 2 cycles past a tick, drop en for 5 cycles -> digits and tick frozen. Raise en -> next tick exactly 2 enabled cycles later.
6. Mid-count (digits 0456, prescaler=2), pulse rst together with load=1 -> d=0000, tick=carry=0. With en held at 1, the first tick arrives 4 cycles after rst deasserts.
